// File: rtl/simd_sat_writeback.sv
// Writeback stage of the M16 SIMD adder: per-nibble saturation override, 2-entry
// valid/ready output FIFO, and sticky saturation status with a saturating event counter.
module simd_sat_writeback #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_result,
  input  logic [1:0]       in_width,
  input  logic [3:0]       sat_enable,
  input  logic [3:0]       sat_sign,
  input  logic [3:0]       sat_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [1:0]       out_width,
  output logic [3:0]       out_sat,
  input  logic             clr_status,
  output logic [3:0]       sticky_sat,
  output logic [CNT_W-1:0] sat_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // MSB nibble of a lane carries the sign, so its limits are 0111/1000; lower nibbles fill with 1s/0s.
  function automatic logic [3:0] sat_nibble(input logic [3:0] nib, input logic en,
                                            input logic sign, input logic last);
    logic [3:0] res;
    if (!en) begin
      res = nib;
    end else if (last) begin
      res = sign ? 4'b1000 : 4'b0111;
    end else begin
      res = sign ? 4'b0000 : 4'b1111;
    end
    return res;
  endfunction

  logic [15:0]      sat_result_s;
  logic             push_s;
  logic             pop_s;

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [15:0]      mem_result_q [2];
  logic [1:0]       mem_width_q  [2];
  logic [3:0]       mem_sat_q    [2];

  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturation overrides applied per nibble before the word is stored.
  always_comb begin
    sat_result_s = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      sat_result_s[4*k +: 4] = sat_nibble(in_result[4*k +: 4], sat_enable[k],
                                          sat_sign[k], sat_last[k]);
    end
  end

  assign in_ready   = (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign push_s     = in_valid && in_ready;
  assign pop_s      = out_valid && out_ready;
  assign out_result = mem_result_q[rd_ptr_q];
  assign out_width  = mem_width_q[rd_ptr_q];
  assign out_sat    = mem_sat_q[rd_ptr_q];
  assign sticky_sat = sticky_q;
  assign sat_count  = cnt_q;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Status next-state: an accept in the clear cycle restarts the status from that word alone.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      if (clr_status) begin
        sticky_d = sat_enable;
        cnt_d    = (|sat_enable) ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
      end else begin
        sticky_d = sticky_q | sat_enable;
        if ((|sat_enable) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
    end else if (clr_status) begin
      sticky_d = 4'b0000;
      cnt_d    = {CNT_W{1'b0}};
    end else begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
    end
  end

  // FIFO control and status state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      sticky_q <= 4'b0000;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_result_q[i] <= 16'h0000;
        mem_width_q[i]  <= 2'b00;
        mem_sat_q[i]    <= 4'b0000;
      end
    end else if (push_s) begin
      mem_result_q[wr_ptr_q] <= sat_result_s;
      mem_width_q[wr_ptr_q]  <= in_width;
      mem_sat_q[wr_ptr_q]    <= sat_enable;
    end
  end

endmodule

// File: tb/tb_simd_sat_writeback.sv
// Self-checking bench for simd_sat_writeback: directed test-plan vectors plus random
// traffic, checked against a queue-based reference model (second instance with CNT_W=2).
module tb_simd_sat_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_result;
  logic [1:0]  in_width;
  logic [3:0]  sat_enable, sat_sign, sat_last;
  logic        out_ready;
  logic        clr_status;

  logic        in_ready, out_valid;
  logic [15:0] out_result;
  logic [1:0]  out_width;
  logic [3:0]  out_sat, sticky_sat;
  logic [7:0]  sat_count;

  logic        in_ready2, out_valid2;
  logic [15:0] out_result2;
  logic [1:0]  out_width2;
  logic [3:0]  out_sat2, sticky_sat2;
  logic [1:0]  sat_count2;

  always #5 clk = ~clk;

  simd_sat_writeback #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_width(in_width), .sat_enable(sat_enable),
    .sat_sign(sat_sign), .sat_last(sat_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_width(out_width),
    .out_sat(out_sat), .clr_status(clr_status), .sticky_sat(sticky_sat),
    .sat_count(sat_count)
  );

  simd_sat_writeback #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_result(in_result), .in_width(in_width), .sat_enable(sat_enable),
    .sat_sign(sat_sign), .sat_last(sat_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_result(out_result2), .out_width(out_width2),
    .out_sat(out_sat2), .clr_status(clr_status), .sticky_sat(sticky_sat2),
    .sat_count(sat_count2)
  );

  typedef struct {
    logic [15:0] result;
    logic [1:0]  width;
    logic [3:0]  sat;
  } word_t;

  word_t       q[$];
  logic [3:0]  m_sticky;
  int          m_events;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_sat(input logic [15:0] r, input logic [3:0] en,
                                          input logic [3:0] sg, input logic [3:0] ls);
    logic [15:0] o;
    logic [3:0]  nib;
    o = r;
    for (int k = 0; k < 4; k++) begin
      if (en[k]) begin
        if (ls[k]) nib = sg[k] ? 4'h8 : 4'h7;
        else       nib = sg[k] ? 4'h0 : 4'hF;
        o[4*k +: 4] = nib;
      end
    end
    return o;
  endfunction

  function automatic int sat_min(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk({tag, ".out_result"}, {16'd0, out_result}, {16'd0, q[0].result});
      chk({tag, ".out_width"},  {30'd0, out_width},  {30'd0, q[0].width});
      chk({tag, ".out_sat"},    {28'd0, out_sat},    {28'd0, q[0].sat});
      chk({tag, ".out_result2"}, {16'd0, out_result2}, {16'd0, q[0].result});
    end
    chk({tag, ".sticky"},     {28'd0, sticky_sat}, {28'd0, m_sticky});
    chk({tag, ".sat_count"},  {24'd0, sat_count},  sat_min(m_events, 255));
    chk({tag, ".sat_count2"}, {30'd0, sat_count2}, sat_min(m_events, 3));
  endtask

  // One clock cycle: drive at negedge, update the model at the edge, check 1ns after it.
  task automatic step(input string tag, input logic v, input logic [15:0] r,
                      input logic [1:0] w, input logic [3:0] en, input logic [3:0] sg,
                      input logic [3:0] ls, input logic ordy, input logic clr);
    logic acc, pp;
    @(negedge clk);
    in_valid = v; in_result = r; in_width = w; sat_enable = en;
    sat_sign = sg; sat_last = ls; out_ready = ordy; clr_status = clr;
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, q.size() < 2});
    acc = v && (q.size() < 2);
    pp  = ordy && (q.size() != 0);
    @(posedge clk);
    #1;
    if (pp) q.delete(0);
    if (acc) begin
      q.push_back('{ref_sat(r, en, sg, ls), w, en});
      if (clr) begin
        m_sticky = en;
        m_events = (en != 4'd0) ? 1 : 0;
      end else begin
        m_sticky = m_sticky | en;
        if (en != 4'd0) m_events++;
      end
    end else if (clr) begin
      m_sticky = 4'd0;
      m_events = 0;
    end
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b0, 16'h0000, 2'b00, 4'h0, 4'h0, 4'h0, ordy, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    m_sticky = 4'd0;
    m_events = 0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = 16'h0; in_width = 2'b00;
    sat_enable = 4'h0; sat_sign = 4'h0; sat_last = 4'h0; out_ready = 1'b0;
    clr_status = 1'b0;
    model_reset();
    #2;
    chk("rst.out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst.in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst.out_result", {16'd0, out_result}, 32'd0);
    chk("rst.out_width",  {30'd0, out_width},  32'd0);
    chk("rst.out_sat",    {28'd0, out_sat},    32'd0);
    chk("rst.sticky",     {28'd0, sticky_sat}, 32'd0);
    chk("rst.sat_count",  {24'd0, sat_count},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 16-bit positive overflow
    step("tp1", 1'b1, 16'h8003, 2'b10, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0);
    chk("tp1.result", {16'd0, out_result}, 32'h7FFF);
    chk("tp1.sticky", {28'd0, sticky_sat}, 32'hF);
    chk("tp1.count",  {24'd0, sat_count},  32'd1);
    idle("tp1.drain", 1'b1);
    step("clr1", 1'b0, 16'h0, 2'b00, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);

    // 8-bit lanes, upper lane negative overflow
    step("tp2", 1'b1, 16'h7F12, 2'b01, 4'b1100, 4'b1100, 4'b1010, 1'b1, 1'b0);
    chk("tp2.result", {16'd0, out_result}, 32'h8012);
    chk("tp2.sticky", {28'd0, sticky_sat}, 32'hC);
    idle("tp2.drain", 1'b1);

    // 4-bit lanes mixed
    step("tp3", 1'b1, 16'h1234, 2'b00, 4'b0101, 4'b0001, 4'b1111, 1'b1, 1'b0);
    chk("tp3.result", {16'd0, out_result}, 32'h1738);
    idle("tp3.drain", 1'b1);

    // Backpressure: A, B accepted, C held until a slot frees
    step("bp.A", 1'b1, 16'hAAAA, 2'b11, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step("bp.B", 1'b1, 16'hBBBB, 2'b01, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("bp.full", {31'd0, in_ready}, 32'd0);
    step("bp.C0", 1'b1, 16'hCCCC, 2'b10, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step("bp.C1", 1'b1, 16'hCCCC, 2'b10, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("bp.stallA", {16'd0, out_result}, 32'hAAAA);
    step("bp.C2", 1'b1, 16'hCCCC, 2'b10, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("bp.headB", {16'd0, out_result}, 32'hBBBB);
    step("bp.C3", 1'b1, 16'hCCCC, 2'b10, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("bp.headC", {16'd0, out_result}, 32'hCCCC);
    idle("bp.d0", 1'b1);
    chk("bp.empty", {31'd0, out_valid}, 32'd0);
    idle("bp.d1", 1'b1);

    // Clear coinciding with an accept
    step("sc.clr", 1'b0, 16'h0, 2'b00, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    step("sc.w0", 1'b1, 16'h1111, 2'b00, 4'b1101, 4'h0, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step("sc.wn", 1'b1, 16'h2222, 2'b00, 4'b0001, 4'h0, 4'hF, 1'b1, 1'b0);
    chk("sc.pre_sticky", {28'd0, sticky_sat}, 32'hD);
    chk("sc.pre_count",  {24'd0, sat_count},  32'd5);
    step("sc.both", 1'b1, 16'h3333, 2'b00, 4'b0010, 4'h0, 4'hF, 1'b1, 1'b1);
    chk("sc.sticky", {28'd0, sticky_sat}, 32'h2);
    chk("sc.count",  {24'd0, sat_count},  32'd1);

    // Counter saturation on the narrow instance
    for (int i = 0; i < 5; i++)
      step("cnt.w", 1'b1, 16'h4444, 2'b00, 4'b1000, 4'h8, 4'h8, 1'b1, 1'b0);
    chk("cnt.hold3", {30'd0, sat_count2}, 32'd3);
    idle("cnt.d", 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
           4'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset with two words buffered
    idle("ar.d0", 1'b1);
    idle("ar.d1", 1'b1);
    idle("ar.d2", 1'b1);
    step("ar.w0", 1'b1, 16'h5555, 2'b00, 4'h1, 4'h0, 4'h1, 1'b0, 1'b0);
    step("ar.w1", 1'b1, 16'h6666, 2'b00, 4'h2, 4'h0, 4'h2, 1'b0, 1'b0);
    chk("ar.full", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar.out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar.in_ready",  {31'd0, in_ready},  32'd1);
    chk("ar.sat_count", {24'd0, sat_count}, 32'd0);
    chk("ar.sticky",    {28'd0, sticky_sat}, 32'd0);
    chk("ar.out_result", {16'd0, out_result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("ar.post", 1'b1, 16'h9ABC, 2'b11, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("ar.post_result", {16'd0, out_result}, 32'h9ABC);
    chk("ar.post_width",  {30'd0, out_width},  32'd3);
    idle("ar.end", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_sat_writeback.md
Name: simd_sat_writeback

Overview:
- Result/writeback stage of the M16 SIMD adder.
- Consumes the raw 16-bit adder sum together with the per-nibble saturation controls (sat_enable, sat_sign, sat_last) that the adder control logic produces.
- Applies the saturation overrides per nibble and buffers the finished words in a 2-entry valid/ready FIFO.
- Keeps sticky per-nibble saturation status and a saturating count of saturation events for software readout.

Parameters:
- CNT_W, 8: width of the saturation-event counter sat_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_result  input  16  raw adder sum. Nibble k = bits [4k+3:4k].
- in_width  input  2  lane mode: 00 = 4x4-bit, 01 = 2x8-bit, 10 = 1x16-bit, 11 = reserved.
- sat_enable  input  4  per-nibble saturation override enable.
- sat_sign  input  4  per-nibble saturation direction. 1 = saturate to the negative limit, 0 = saturate to the positive limit.
- sat_last  input  4  per-nibble flag; 1 = this nibble is the MSB nibble of its lane.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.
- out_result  output  16  saturated result.
- out_width  output  2  in_width captured with the word.
- out_sat  output  4  sat_enable captured with the word.
- clr_status  input  1  synchronous clear of sticky_sat and sat_count.
- sticky_sat  output  4  per-nibble OR of out_sat over all accepted words since the last clear.
- sat_count  output  CNT_W  number of accepted words with any sat_enable bit set, saturating at all-ones.

Behaviour:
- Reset (rst_n=0, async): FIFO empty, out_valid=0, in_ready=1, out_result=0, out_width=0, out_sat=0, sticky_sat=0, sat_count=0. Reset mid-transfer discards all buffered words.
- Accept: a word is taken when in_valid && in_ready at the clk edge. Pop occurs when out_valid && out_ready.
- Saturation is applied combinationally before storage. For each nibble k:
  - sat_enable[k]=0: nibble passes unchanged.
  - sat_enable[k]=1, sat_last[k]=1: nibble = sat_sign[k] ? 4'b1000 : 4'b0111.
  - sat_enable[k]=1, sat_last[k]=0: nibble = sat_sign[k] ? 4'b0000 : 4'b1111.
- in_width is carried through only; it does not gate saturation. Mode 11 is stored and forwarded unchanged.
- FIFO:
  - 2 entries; 1-bit read/write pointers plus a count (0..2). Pointers wrap 1->0.
  - in_ready = (count != 2). It is registered-state based only, with no combinational path from out_ready.
  - out_valid = (count != 0). The out_* signals come from the head entry and stay stable while out_valid && !out_ready.
  - Latency: a word accepted into an empty FIFO appears on out_* the next cycle. There is no same-cycle bypass.
  - Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at count 1. At count 2 no push occurs (in_ready=0); a pop that cycle frees a slot, and in_ready=1 on the following cycle.
  - Push into a full FIFO is impossible; a pop from an empty FIFO is ignored.
- Status registers (updated on accept, not on pop):
  - sticky_sat: on accept, sticky_sat |= sat_enable.
  - sat_count: on accept with |sat_enable, increment, holding at 2^CNT_W-1.
  - clr_status alone clears both registers to 0.
  - clr_status in the same cycle as an accept: the accept wins over the clear. Result is sticky_sat = sat_enable and sat_count = (|sat_enable ? 1 : 0).
- Words with sat_enable=0 do not affect the status registers.

Test Plan:
- 16-bit positive overflow: in_result=16'h8003, width=10, sat_enable=1111, sat_sign=0000, sat_last=1000 -> one cycle later out_valid=1, out_result=16'h7FFF, out_sat=1111, sticky_sat=1111, sat_count=1.
- 8-bit lanes, upper lane negative overflow only: in_result=16'h7F12, width=01, sat_enable=1100, sat_sign=1100, sat_last=1010 -> out_result=16'h8012, sticky_sat=1100.
- 4-bit lanes mixed: in_result=16'h1234, width=00, sat_enable=0101, sat_sign=0001, sat_last=1111 -> out_result=16'h1738.
- Backpressure:
  - Hold out_ready=0 and push words A, B, C back-to-back -> A and B accepted, in_ready=0 from the cycle after B, C held.
  - Raise out_ready -> A, B, C emerge in order with out_* stable while stalled, and no word is lost or duplicated.
- Status clear: assert clr_status in the same cycle as accepting a word with sat_enable=0010 while sticky_sat=1101 and sat_count=5 -> sticky_sat=0010, sat_count=1 next cycle.
- Counter and reset:
  - With CNT_W=2, accept 5 saturating words -> sat_count holds at 3.
  - Drop rst_n with 2 words buffered -> out_valid=0, in_ready=1, sat_count=0 immediately, without waiting for a clock edge.
